// File: rtl/data_stack_if.sv
// Operation and observation signals of the data stack.
// master issues stack ops; slave is the stack itself.
interface data_stack_if #(
   parameter int unsigned PTR_W = 4
);
   logic [2:0]     stackOP;
   logic [15:0]    stackWriteData;
   logic [15:0]    top;
   logic [15:0]    next;
   logic [PTR_W:0] depth;
   logic           empty;
   logic           full;
   logic           overflow;
   logic           underflow;

   modport master (
      output stackOP, stackWriteData,
      input  top, next, depth, empty, full, overflow, underflow
   );

   modport slave (
      input  stackOP, stackWriteData,
      output top, next, depth, empty, full, overflow, underflow
   );
endinterface

// File: rtl/data_stack.sv
// Data stack with one op per cycle: top/next live in registers, deeper entries
// in an async-read array addressed by depth-3. Illegal ops leave state untouched.
module data_stack #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PTR_W = 4
) (
   input logic        CLK,
   input logic        reset,
   data_stack_if.slave bus
);
   localparam int unsigned CW      = PTR_W + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   localparam logic [2:0] OP_NOP     = 3'b000;
   localparam logic [2:0] OP_PUSH    = 3'b001;
   localparam logic [2:0] OP_POP     = 3'b010;
   localparam logic [2:0] OP_REPLACE = 3'b011;
   localparam logic [2:0] OP_POP2    = 3'b100;
   localparam logic [2:0] OP_BINOP   = 3'b101;
   localparam logic [2:0] OP_DUP     = 3'b110;
   localparam logic [2:0] OP_SWAP    = 3'b111;

   logic [15:0]   top_q, top_d;
   logic [15:0]   next_q, next_d;
   logic [CW-1:0] depth_q, depth_d;
   logic          empty_q, empty_d;
   logic          full_q, full_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;

   // Array is sized to a power of two so the pointer indexes it exactly;
   // only entries 0..DEPTH-3 are ever written.
   logic [15:0]    mem_q [DEPTH];
   logic           mem_we;
   logic [PTR_W-1:0] mem_wa;
   logic [15:0]    mem_wd;

   logic        has1, has2, has3, has4, is_full;
   logic [15:0] below1, below2;

   assign has1    = depth_q != '0;
   assign has2    = depth_q >= CW'(2);
   assign has3    = depth_q >= CW'(3);
   assign has4    = depth_q >= CW'(4);
   assign is_full = depth_q == DEPTH_C;

   // Entries under next, forced to zero when they are beyond the current depth.
   assign below1 = has3 ? mem_q[PTR_W'(depth_q - CW'(3))] : '0;
   assign below2 = has4 ? mem_q[PTR_W'(depth_q - CW'(4))] : '0;

   always_comb begin
      top_d       = top_q;
      next_d      = next_q;
      depth_d     = depth_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      mem_we      = 1'b0;
      mem_wa      = PTR_W'(depth_q - CW'(2));
      mem_wd      = next_q;

      case (bus.stackOP)
         OP_NOP: ;
         OP_PUSH, OP_DUP: begin
            if (bus.stackOP == OP_DUP && !has1) begin
               underflow_d = 1'b1;
            end else if (is_full) begin
               overflow_d = 1'b1;
            end else begin
               mem_we  = has2;
               next_d  = top_q;
               top_d   = (bus.stackOP == OP_DUP) ? top_q : bus.stackWriteData;
               depth_d = depth_q + CW'(1);
            end
         end
         OP_POP: begin
            if (!has1) begin
               underflow_d = 1'b1;
            end else begin
               top_d   = next_q;
               next_d  = below1;
               depth_d = depth_q - CW'(1);
            end
         end
         OP_REPLACE: begin
            if (!has1) underflow_d = 1'b1;
            else       top_d       = bus.stackWriteData;
         end
         OP_POP2: begin
            if (!has2) begin
               underflow_d = 1'b1;
            end else begin
               top_d   = below1;
               next_d  = below2;
               depth_d = depth_q - CW'(2);
            end
         end
         OP_BINOP: begin
            if (!has2) begin
               underflow_d = 1'b1;
            end else begin
               top_d   = bus.stackWriteData;
               next_d  = below1;
               depth_d = depth_q - CW'(1);
            end
         end
         OP_SWAP: begin
            if (!has2) begin
               underflow_d = 1'b1;
            end else begin
               top_d  = next_q;
               next_d = top_q;
            end
         end
         default: ;
      endcase

      empty_d = depth_d == '0;
      full_d  = depth_d == DEPTH_C;
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         top_q       <= '0;
         next_q      <= '0;
         depth_q     <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         top_q       <= top_d;
         next_q      <= next_d;
         depth_q     <= depth_d;
         empty_q     <= empty_d;
         full_q      <= full_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (mem_we) mem_q[mem_wa] <= mem_wd;
   end

   assign bus.top       = top_q;
   assign bus.next      = next_q;
   assign bus.depth     = depth_q;
   assign bus.empty     = empty_q;
   assign bus.full      = full_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_data_stack.sv
// Scoreboard bench for data_stack: a queue-based reference stack predicts every
// output after each op; predictions are queued at issue and compared after the edge.
module tb_data_stack;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned PTR_W = 4;

   localparam logic [2:0] OP_NOP     = 3'b000;
   localparam logic [2:0] OP_PUSH    = 3'b001;
   localparam logic [2:0] OP_POP     = 3'b010;
   localparam logic [2:0] OP_REPLACE = 3'b011;
   localparam logic [2:0] OP_POP2    = 3'b100;
   localparam logic [2:0] OP_BINOP   = 3'b101;
   localparam logic [2:0] OP_DUP     = 3'b110;
   localparam logic [2:0] OP_SWAP    = 3'b111;

   typedef struct {
      logic [15:0]    top;
      logic [15:0]    next;
      logic [PTR_W:0] depth;
      logic           empty;
      logic           full;
      logic           ovf;
      logic           unf;
   } exp_t;

   logic CLK = 1'b0;
   logic reset;

   exp_t        exp_q[$];
   logic [15:0] model[$];
   logic        m_ovf;
   logic        m_unf;
   int          n_vec  = 0;
   int          n_miss = 0;
   int          step   = 0;

   always #5 CLK = ~CLK;

   data_stack_if #(.PTR_W(PTR_W)) bus ();

   data_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s (step %0d): got %0h expected %0h", tag, step, got, exp);
      end
   endtask

   task automatic model_op(input logic [2:0] op, input logic [15:0] d);
      int n;
      logic [15:0] t;
      n = model.size();
      case (op)
         OP_PUSH:    if (n == DEPTH) m_ovf = 1'b1; else model.push_back(d);
         OP_POP:     if (n < 1) m_unf = 1'b1; else void'(model.pop_back());
         OP_REPLACE: if (n < 1) m_unf = 1'b1; else model[n-1] = d;
         OP_POP2:    if (n < 2) m_unf = 1'b1;
                     else begin void'(model.pop_back()); void'(model.pop_back()); end
         OP_BINOP:   if (n < 2) m_unf = 1'b1;
                     else begin
                        void'(model.pop_back()); void'(model.pop_back());
                        model.push_back(d);
                     end
         OP_DUP:     if (n < 1) m_unf = 1'b1;
                     else if (n == DEPTH) m_ovf = 1'b1;
                     else model.push_back(model[n-1]);
         OP_SWAP:    if (n < 2) m_unf = 1'b1;
                     else begin t = model[n-1]; model[n-1] = model[n-2]; model[n-2] = t; end
         default: ;
      endcase
   endtask

   task automatic push_expected();
      exp_t e;
      int   n;
      n       = model.size();
      e.top   = (n >= 1) ? model[n-1] : 16'h0;
      e.next  = (n >= 2) ? model[n-2] : 16'h0;
      e.depth = (PTR_W+1)'(n);
      e.empty = (n == 0);
      e.full  = (n == DEPTH);
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      exp_q.push_back(e);
   endtask

   task automatic check_outputs();
      exp_t e;
      e = exp_q.pop_front();
      check("top",       32'(bus.top),       32'(e.top));
      check("next",      32'(bus.next),      32'(e.next));
      check("depth",     32'(bus.depth),     32'(e.depth));
      check("empty",     32'(bus.empty),     32'(e.empty));
      check("full",      32'(bus.full),      32'(e.full));
      check("overflow",  32'(bus.overflow),  32'(e.ovf));
      check("underflow", 32'(bus.underflow), 32'(e.unf));
   endtask

   task automatic do_op(input logic [2:0] op, input logic [15:0] d);
      step++;
      bus.stackOP        = op;
      bus.stackWriteData = d;
      model_op(op, d);
      push_expected();
      @(posedge CLK);
      #1;
      check_outputs();
   endtask

   task automatic apply_reset();
      @(negedge CLK);
      reset       = 1'b1;
      bus.stackOP = OP_NOP;
      repeat (2) @(negedge CLK);
      reset = 1'b0;
      model.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   initial begin
      reset              = 1'b1;
      bus.stackOP        = OP_NOP;
      bus.stackWriteData = 16'h0;
      m_ovf              = 1'b0;
      m_unf              = 1'b0;
      #12;
      check("rst_top",   32'(bus.top),   32'h0);
      check("rst_next",  32'(bus.next),  32'h0);
      check("rst_depth", 32'(bus.depth), 32'h0);
      check("rst_empty", 32'(bus.empty), 32'h1);
      check("rst_flags", 32'({bus.full, bus.overflow, bus.underflow}), 32'h0);
      @(negedge CLK);
      reset = 1'b0;

      // Basic push/pop.
      do_op(OP_PUSH, 16'h0001);
      do_op(OP_PUSH, 16'h0002);
      do_op(OP_PUSH, 16'h0003);
      check("plan_top3", 32'(bus.top), 32'h3);
      check("plan_next3", 32'(bus.next), 32'h2);
      do_op(OP_POP, 16'hDEAD);
      check("plan_pop_top", 32'(bus.top), 32'h2);

      // BINOP down to depth 1, then SWAP with too few entries.
      do_op(OP_POP, 16'h0);
      do_op(OP_POP, 16'h0);
      do_op(OP_PUSH, 16'h0007);
      do_op(OP_PUSH, 16'h0005);
      do_op(OP_BINOP, 16'h000C);
      check("plan_binop_top", 32'(bus.top), 32'hC);
      do_op(OP_SWAP, 16'hFFFF);
      check("plan_swap_unf", 32'(bus.underflow), 32'h1);

      // DUP/SWAP on a single entry, then PUSH+SWAP.
      do_op(OP_REPLACE, 16'h00AA);
      do_op(OP_DUP, 16'h5555);
      do_op(OP_SWAP, 16'h0);
      do_op(OP_PUSH, 16'h1234);
      do_op(OP_SWAP, 16'h0);
      check("plan_swap_next", 32'(bus.next), 32'h1234);

      // Fill to full, overflow, drain, underflow on empty.
      apply_reset();
      for (int i = 1; i <= DEPTH; i++) do_op(OP_PUSH, 16'(i));
      check("plan_full", 32'(bus.full), 32'h1);
      do_op(OP_PUSH, 16'hFFFF);
      do_op(OP_DUP, 16'h0);
      check("plan_ovf_top", 32'(bus.top), 32'h10);
      for (int i = 0; i < DEPTH; i++) do_op(OP_POP, 16'h0);
      do_op(OP_POP, 16'h0);
      do_op(OP_PUSH, 16'h0042);
      check("plan_unf_sticky", 32'(bus.underflow), 32'h1);

      // Random mix exercising POP2, BINOP and deep array reads.
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         logic [2:0] op;
         op = 3'($urandom_range(0, 7));
         if (i < 200 && model.size() < 6 && op != OP_NOP) op = OP_PUSH;
         do_op(op, 16'($urandom));
      end

      // Asynchronous reset mid-cycle with a PUSH pending.
      apply_reset();
      for (int i = 1; i <= 5; i++) do_op(OP_PUSH, 16'(i * 17));
      bus.stackOP        = OP_PUSH;
      bus.stackWriteData = 16'hBEEF;
      #3;
      reset = 1'b1;
      #1;
      check("arst_top",   32'(bus.top),   32'h0);
      check("arst_next",  32'(bus.next),  32'h0);
      check("arst_depth", 32'(bus.depth), 32'h0);
      check("arst_empty", 32'(bus.empty), 32'h1);
      repeat (2) @(negedge CLK);
      reset       = 1'b0;
      bus.stackOP = OP_NOP;
      model.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      do_op(OP_PUSH, 16'h0009);
      check("arst_push_top", 32'(bus.top), 32'h9);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
